crossbar_route_ctrl: RTL and testbench

CROSSBAR_ROUTE_CTRL -- requirements
Module: crossbar_route_ctrl

---
 rtl/crossbar_route_ctrl.sv | 94 +++++++++
 tb/tb_crossbar_route_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/crossbar_route_ctrl.sv
// crossbar_route_ctrl: searches the 5-switch network for the smallest control word realising a requested permutation
module crossbar_route_ctrl #(
  parameter bit HOLD_ON_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_dest,
  output logic [4:0] ctrl,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_err
);
  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;
  state_t state, state_n;
  logic [7:0] dest, dest_n;
  logic [4:0] cand, cand_n, ctrl_n;
  logic [1:0] err_n;
  logic [1:0] f [4];
  logic [1:0] a, b, c, d, bp, cp, o1, o2, o3, o4;
  logic distinct, match;
  assign f[0] = dest[1:0];
  assign f[1] = dest[3:2];
  assign f[2] = dest[5:4];
  assign f[3] = dest[7:6];
  assign distinct = f[0] != f[1] && f[0] != f[2] && f[0] != f[3] &&
                    f[1] != f[2] && f[1] != f[3] && f[2] != f[3];
  // o1..o4 hold the index of the input that reaches each output under cand
  always_comb begin
    a  = cand[0] ? 2'd1 : 2'd0;
    b  = cand[0] ? 2'd0 : 2'd1;
    c  = cand[3] ? 2'd3 : 2'd2;
    d  = cand[3] ? 2'd2 : 2'd3;
    bp = cand[2] ? c : b;
    cp = cand[2] ? b : c;
    o1 = cand[1] ? bp : a;
    o2 = cand[1] ? a : bp;
    o3 = cand[4] ? d : cp;
    o4 = cand[4] ? cp : d;
  end
  assign match = f[o1] == 2'd0 && f[o2] == 2'd1 && f[o3] == 2'd2 && f[o4] == 2'd3;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  always_comb begin
    state_n = state;
    dest_n  = dest;
    cand_n  = cand;
    ctrl_n  = ctrl;
    err_n   = rsp_err;
    case (state)
      IDLE: if (req_valid) begin
        dest_n  = req_dest;
        state_n = CHECK;
      end
      CHECK: if (!distinct) begin
        state_n = DONE;
        err_n   = 2'b01;
        ctrl_n  = HOLD_ON_ERR ? ctrl : 5'b00000;
      end else begin
        state_n = SEARCH;
        cand_n  = 5'd0;
      end
      SEARCH: if (match) begin
        state_n = DONE;
        err_n   = 2'b00;
        ctrl_n  = cand;
      end else if (cand != 5'd31) begin
        cand_n = cand + 5'd1;
      end else begin
        state_n = DONE;
        err_n   = 2'b10;
        ctrl_n  = HOLD_ON_ERR ? ctrl : 5'b00000;
      end
      DONE: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dest    <= '0;
      cand    <= '0;
      ctrl    <= '0;
      rsp_err <= '0;
    end else begin
      state   <= state_n;
      dest    <= dest_n;
      cand    <= cand_n;
      ctrl    <= ctrl_n;
      rsp_err <= err_n;
    end
  end
endmodule

// File: tb/tb_crossbar_route_ctrl.sv
// tb_crossbar_route_ctrl: scoreboard bench; a hold-on-error and a clear-on-error instance run in lockstep
module tb_crossbar_route_ctrl;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic [7:0] req_dest = '0;
  logic req_ready, rsp_valid, req_ready0, rsp_valid0;
  logic [4:0] ctrl, ctrl0;
  logic [1:0] rsp_err, rsp_err0;
  int errs = 0, checks = 0, cyc = 0;
  typedef struct {logic [1:0] err; logic [4:0] c1; logic [4:0] c0; int at;} exp_t;
  exp_t q[$];

  crossbar_route_ctrl dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .ctrl(ctrl), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err));
  crossbar_route_ctrl #(.HOLD_ON_ERR(1'b0)) dut0 (.clk(clk), .rst(rst), .req_valid(req_valid),
    .req_ready(req_ready0), .req_dest(req_dest), .ctrl(ctrl0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err0));

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (rst || !rsp_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL spurious_rsp: got response err=%0h ctrl=%0h with nothing expected", rsp_err, ctrl);
        end else begin
          e = q.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("ctrl", ctrl, e.c1);
          chk("ctrl_clear_variant", ctrl0, e.c0);
          chk("rsp_err_clear_variant", rsp_err0, e.err);
          chk("latency_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] err, input logic [4:0] c1,
                      input logic [4:0] c0, input int lat, input int hold, input bit early);
    int n;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1;
    req_dest = d;
    if (early) rsp_ready = 1;
    @(posedge clk);
    #1;
    q.push_back('{err, c1, c0, cyc + lat});
    req_valid = 0;
    req_dest = ~d;
    chk("req_ready_busy", req_ready, 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errs++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, required one", n);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ctrl", ctrl, c1);
      chk("hold_err", rsp_err, err);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    chk("back_to_idle", req_ready, 1);
    chk("valid_dropped", rsp_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err", rsp_err, 0);
    #20 rst = 0;
    send(8'hE4, 2'b00, 5'd0, 5'd0, 2, 0, 0);
    send(8'hB1, 2'b00, 5'd9, 5'd9, 11, 5, 0);
    send(8'h00, 2'b01, 5'd9, 5'd0, 1, 0, 0);
    send(8'h4E, 2'b10, 5'd9, 5'd0, 33, 0, 0);
    send(8'hE1, 2'b00, 5'd1, 5'd1, 3, 0, 0);
    send(8'hD8, 2'b00, 5'd4, 5'd4, 6, 0, 0);
    send(8'h18, 2'b01, 5'd4, 5'd0, 1, 0, 0);
    send(8'hB4, 2'b00, 5'd8, 5'd8, 10, 0, 1);
    @(negedge clk);
    req_valid = 1;
    req_dest = 8'h4E;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_ctrl", ctrl, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    @(negedge clk);
    rst = 0;
    #1 chk("ready_after_rst", req_ready, 1);
    send(8'hE4, 2'b00, 5'd0, 5'd0, 2, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
